// File: rtl/ip_feeder.sv
// ip_feeder: streams 4-lane x/w chunks into an external inner-product unit,
// carries the running partial sum between chunks and returns the final dot
// product over a valid/ready result handshake.
// Optional feature: define IP_FEEDER_BIAS_EN to add a bias input that seeds
// the accumulation (first chunk then adds bias, zero chunks returns bias).
module ip_feeder #(
  parameter int unsigned bitwidth = 8,
  parameter int unsigned cntwidth = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [cntwidth-1:0]   num_chunks,
`ifdef IP_FEEDER_BIAS_EN
  input  logic [bitwidth-1:0]   bias,
`endif
  input  logic [4*bitwidth-1:0] in_x,
  input  logic [4*bitwidth-1:0] in_w,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [bitwidth-1:0]   x_0,
  output logic [bitwidth-1:0]   x_1,
  output logic [bitwidth-1:0]   x_2,
  output logic [bitwidth-1:0]   x_3,
  output logic [bitwidth-1:0]   w_0,
  output logic [bitwidth-1:0]   w_1,
  output logic [bitwidth-1:0]   w_2,
  output logic [bitwidth-1:0]   w_3,
  output logic [bitwidth-1:0]   psum,
  output logic                  sel,
  input  logic [bitwidth-1:0]   sum,
  output logic [bitwidth-1:0]   result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef IP_FEEDER_BIAS_EN
  localparam bit BiasEn = 1'b1;
  logic [bitwidth-1:0] init_val;
  assign init_val = bias;
`else
  localparam bit BiasEn = 1'b0;
  logic [bitwidth-1:0] init_val;
  assign init_val = '0;
`endif

  state_e              state_q, state_d;
  logic [cntwidth-1:0] remaining_q, remaining_d;
  logic [bitwidth-1:0] psum_q, psum_d;
  logic                first_q, first_d;
  logic [bitwidth-1:0] result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                accept;

  assign accept = in_ready_q & in_valid;

  // Next-state and next-register computation for the feeder FSM.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    psum_d      = psum_q;
    first_d     = first_q;
    result_d    = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          remaining_d = num_chunks;
          psum_d      = init_val;
          first_d     = 1'b1;
          if (num_chunks == '0) begin
            result_d = init_val;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          psum_d      = sum;
          first_d     = 1'b0;
          remaining_d = remaining_q - cntwidth'(1);
          if (remaining_q == cntwidth'(1)) begin
            result_d = sum;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d     = (state_d == RUN);
    busy_d         = (state_d != IDLE);
    result_valid_d = (state_d == DONE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      psum_q         <= '0;
      first_q        <= 1'b1;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      psum_q         <= psum_d;
      first_q        <= first_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
    end
  end

  // Lane fan-out and partial-sum feed to the inner-product unit, live only in RUN.
  always_comb begin
    x_0  = '0;
    x_1  = '0;
    x_2  = '0;
    x_3  = '0;
    w_0  = '0;
    w_1  = '0;
    w_2  = '0;
    w_3  = '0;
    psum = '0;
    sel  = 1'b0;
    if (state_q == RUN) begin
      x_0  = in_x[0*bitwidth +: bitwidth];
      x_1  = in_x[1*bitwidth +: bitwidth];
      x_2  = in_x[2*bitwidth +: bitwidth];
      x_3  = in_x[3*bitwidth +: bitwidth];
      w_0  = in_w[0*bitwidth +: bitwidth];
      w_1  = in_w[1*bitwidth +: bitwidth];
      w_2  = in_w[2*bitwidth +: bitwidth];
      w_3  = in_w[3*bitwidth +: bitwidth];
      psum = psum_q;
      sel  = BiasEn | ~first_q;
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_ip_feeder.sv
// Scoreboard bench for ip_feeder: stimulus pushes hand-computed chunk and
// result expectations; a negedge monitor pops and compares on handshakes.
module tb_ip_feeder;

`ifdef IP_FEEDER_BIAS_EN
  localparam logic [7:0] BIAS    = 8'd7;
  localparam bit         BIAS_EN = 1'b1;
`else
  localparam logic [7:0] BIAS    = 8'd0;
  localparam bit         BIAS_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_chunks;
  logic [31:0] in_x, in_w;
  logic        in_valid, in_ready;
  logic [7:0]  x_0, x_1, x_2, x_3, w_0, w_1, w_2, w_3;
  logic [7:0]  psum, sum, result;
  logic        sel, result_valid, result_ready, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] chunk_q[$];
  logic [7:0] res_q[$];
  logic [8:0] ce;
  logic [7:0] re;

  ip_feeder #(.bitwidth(8), .cntwidth(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks),
`ifdef IP_FEEDER_BIAS_EN
    .bias(BIAS),
`endif
    .in_x(in_x), .in_w(in_w), .in_valid(in_valid), .in_ready(in_ready),
    .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3),
    .w_0(w_0), .w_1(w_1), .w_2(w_2), .w_3(w_3),
    .psum(psum), .sel(sel), .sum(sum),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inner-product unit model: sum of lane products plus optional psum, mod 256.
  always_comb sum = 8'(x_0 * w_0 + x_1 * w_1 + x_2 * w_2 + x_3 * w_3 + (sel ? psum : 8'd0));

  function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares sel/psum on each accepted chunk and result on each result handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && in_ready) begin
        if (chunk_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_chunk: accepted chunk with no expectation queued");
        end else begin
          ce = chunk_q.pop_front();
          chk("chunk_sel", 32'(sel), 32'(ce[8]));
          chk("chunk_psum", 32'(psum), 32'(ce[7:0]));
        end
      end
      if (result_valid && result_ready) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: result %0d with no expectation queued", result);
        end else begin
          re = res_q.pop_front();
          chk("result_value", 32'(result), 32'(re));
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    num_chunks = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_chunk(input logic [31:0] x, input logic [31:0] w,
                            input bit esel, input logic [7:0] epsum, input int gap);
    bit ok;
    repeat (gap) begin
      @(negedge clk);
      chk("in_ready_gap", 32'(in_ready), 32'd1);
      chk("busy_gap", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    chunk_q.push_back({esel, epsum});
    in_x = x;
    in_w = w;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL chunk_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic take_result(input logic [7:0] exp, input int hold, input bit start_hs);
    res_q.push_back(exp);
    @(negedge clk);
    chk("result_latency", 32'(result_valid), 32'd1);
    repeat (hold) begin
      @(negedge clk);
      chk("result_held_valid", 32'(result_valid), 32'd1);
      chk("result_stable", 32'(result), 32'(exp));
    end
    @(posedge clk); #1;
    result_ready = 1'b1;
    if (start_hs) begin
      start = 1'b1;
      num_chunks = 8'd1;
    end
    @(posedge clk); #1;
    result_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(result_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
  endtask

  localparam logic [31:0] ONES4 = 32'h01010101;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_chunks = 8'd0;
    in_x = 32'hFFFFFFFF;
    in_w = 32'hFFFFFFFF;
    in_valid = 1'b0;
    result_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_psum", 32'(psum), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    chk("reset_x0_idle", 32'(x_0), 32'd0);
    chk("reset_w3_idle", 32'(w_3), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Two chunks: 10 then 10+8=18.
    do_start(8'd2);
    send_chunk(pk(1, 2, 3, 4), ONES4, BIAS_EN, BIAS, 1);
    send_chunk(pk(2, 2, 2, 2), ONES4, 1'b1, 8'(10 + BIAS), 0);
    take_result(8'(18 + BIAS), 0, 1'b0);

    // Three chunks of 8 with input bubbles and a slow consumer.
    do_start(8'd3);
    send_chunk(ONES4, pk(2, 2, 2, 2), BIAS_EN, BIAS, 2);
    send_chunk(ONES4, pk(2, 2, 2, 2), 1'b1, 8'(8 + BIAS), 2);
    send_chunk(ONES4, pk(2, 2, 2, 2), 1'b1, 8'(16 + BIAS), 2);
    take_result(8'(24 + BIAS), 5, 1'b0);

    // 16*16 = 256 wraps to 0.
    do_start(8'd1);
    send_chunk(pk(16, 16, 0, 0), pk(16, 0, 0, 0), BIAS_EN, BIAS, 0);
    take_result(8'(0 + BIAS), 0, 1'b0);

    // Zero chunks goes straight to DONE with the initial value.
    do_start(8'd0);
    take_result(BIAS, 2, 1'b0);

`ifdef IP_FEEDER_BIAS_EN
    // 255*255 = 1 mod 256 per lane: 4 + bias 7 = 11.
    do_start(8'd1);
    send_chunk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 8'd7, 0);
    take_result(8'd11, 0, 1'b0);
`endif

    // Reset after 1 of 4 chunks, then a fresh single-chunk operation.
    do_start(8'd4);
    send_chunk(ONES4, ONES4, BIAS_EN, BIAS, 0);
    do_reset();
    do_start(8'd1);
    send_chunk(pk(3, 0, 0, 0), pk(5, 0, 0, 0), BIAS_EN, BIAS, 0);
    take_result(8'(15 + BIAS), 0, 1'b0);

    // Start during RUN (with a different count) and during the result handshake is ignored.
    do_start(8'd3);
    send_chunk(ONES4, ONES4, BIAS_EN, BIAS, 0);
    do_start(8'd1);
    @(negedge clk);
    chk("run_start_ignored_busy", 32'(busy), 32'd1);
    chk("run_start_ignored_ready", 32'(in_ready), 32'd1);
    send_chunk(ONES4, ONES4, 1'b1, 8'(4 + BIAS), 1);
    @(negedge clk);
    chk("count_kept_valid", 32'(result_valid), 32'd0);
    chk("count_kept_ready", 32'(in_ready), 32'd1);
    send_chunk(ONES4, ONES4, 1'b1, 8'(8 + BIAS), 1);
    take_result(8'(12 + BIAS), 0, 1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("hs_start_dropped", 32'(busy), 32'd0);
    end

    repeat (3) @(posedge clk);
    chk("chunk_queue_drained", 32'(chunk_q.size()), 32'd0);
    chk("result_queue_drained", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ip_feeder.md
IP_FEEDER -- requirements
Module: ip_feeder

Interface
REQ-001 SHALL have parameter bitwidth, default 8, giving the lane, psum and result width.
REQ-002 SHALL have parameter cntwidth, default 8, giving the chunk counter width.
REQ-003 SHALL have ports: clk input 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have ports: reset input 1, synchronous active-high reset.
REQ-005 SHALL have ports: start input 1, single-cycle pulse that begins a dot product.
REQ-006 SHALL have ports: num_chunks input cntwidth, the number of 4-lane chunks, sampled on an accepted start.
REQ-007 SHALL have ports: in_x input 4*bitwidth, packed x lanes; lane k is bits [k*bitwidth +: bitwidth].
REQ-008 SHALL have ports: in_w input 4*bitwidth, packed w lanes with the same packing as in_x.
REQ-009 SHALL have ports: in_valid input 1 and in_ready output 1, the chunk handshake.
REQ-010 SHALL have ports: x_0..x_3 and w_0..w_3, outputs bitwidth each, driven to the inner-product unit.
REQ-011 SHALL have ports: psum output bitwidth, sel output 1, and sum input bitwidth, the inner-product unit interface.
REQ-012 SHALL have ports: result output bitwidth, result_valid output 1 and result_ready input 1, the result handshake.
REQ-013 SHALL have ports: busy output 1, high in every state except IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE with start=1, latch num_chunks into remaining and go to RUN; if num_chunks=0, it SHALL instead load result with the initial value and go to DONE.
REQ-016 SHALL drive in_ready=1 only in RUN; a chunk is accepted in any cycle where in_valid and in_ready are both 1.
REQ-017 SHALL, in RUN, drive x_k and w_k combinationally from in_x and in_w lane k; outside RUN, x_k, w_k and psum SHALL be 0.
REQ-018 SHALL drive sel=0 for the first chunk (first=1) and sel=1 for later chunks; psum SHALL be psum_reg.
REQ-019 SHALL, on an accepted chunk, load sum into psum_reg, clear first, and decrement remaining; arithmetic is modulo 2^bitwidth with no saturation.
REQ-020 SHALL, on acceptance of the chunk where remaining=1, load sum into result and go to DONE in the same edge.
REQ-021 SHALL, in DONE, hold result_valid=1 and result stable until result_ready=1, then go to IDLE in the next state.
REQ-022 SHALL hold state and registers unchanged in RUN when in_valid=0 (bubbles allowed).
REQ-023 SHALL ignore start outside IDLE; num_chunks SHALL NOT be re-sampled.
REQ-024 SHALL, with result_valid and result_ready both 1 and start=1 in the same cycle, go to IDLE only; start is dropped.
REQ-025 SHALL have result latency from the last accepted chunk equal to 1 cycle, i.e. result_valid rises on the following edge.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, set state=IDLE, psum_reg=0, result=0, result_valid=0, in_ready=0, busy=0, remaining=0 and first=1.
REQ-027 SHALL give reset priority over all other inputs; a reset mid-RUN or mid-DONE SHALL abandon the operation with no result emitted.

Configuration
REQ-028 SHALL use macro IP_FEEDER_BIAS_EN.
REQ-029 SHALL, when IP_FEEDER_BIAS_EN is defined, add input bias (bitwidth), sampled on an accepted start; the first chunk SHALL drive sel=1 with psum=bias, and num_chunks=0 SHALL yield result=bias.
REQ-030 SHALL, when IP_FEEDER_BIAS_EN is undefined, have no bias port, drive sel=0 on the first chunk, and yield result=0 for num_chunks=0.

Verification (bitwidth=8, bench models ip as sum = Σx_k*w_k + (sel?psum:0) mod 256)
REQ-031 SHALL cover: start, num_chunks=2; chunks x=(1,2,3,4) w=(1,1,1,1), then x=(2,2,2,2) w=(1,1,1,1) -> sel 0 then 1, result=18, result_valid one cycle after the 2nd chunk.
REQ-032 SHALL cover: num_chunks=3 with in_valid gaps of 2 cycles and result_ready held low 5 cycles -> in_ready high throughout RUN, result stable while waiting, IDLE after handshake.
REQ-033 SHALL cover: num_chunks=1, x=(16,16,0,0) w=(16,0,0,0) -> result=0 (256 wraps modulo 256).
REQ-034 SHALL cover: num_chunks=0 -> DONE directly, result=0 (or =bias=7 with IP_FEEDER_BIAS_EN, where bias=7 and 1 chunk of all-ones x,w gives result=11).
REQ-035 SHALL cover: reset asserted after 1 of 4 chunks, then a new start with num_chunks=1 -> no stale result; first chunk uses sel=0 and psum=0.
REQ-036 SHALL cover: start pulsed during RUN and in the DONE-handshake cycle -> ignored; chunk count is unchanged.
